// File: rtl/cbl_pkg.sv
// rtl/cbl_pkg.sv - shared encodings for the control-store branch-logic sequencer
package cbl_pkg;

  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    TIPO_NEXT   = 2'b00,
    TIPO_JUMP   = 2'b01,
    TIPO_DECODE = 2'b10
  } tipo_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_TRAP = 2'b10
  } state_t;

  localparam logic [10:0] TRAP_ADDRESS_DEFAULT = 11'h7F0;

  // Bit positions inside the {n,z,v,c} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  function automatic tipo_t cond_decode(input cond_t condSel, input logic [3:0] flags,
                                        input logic ir13);
    tipo_t result;
    result = TIPO_NEXT;
    case (condSel)
      COND_NEXT:   result = TIPO_NEXT;
      COND_N:      result = flags[FLAG_N] ? TIPO_JUMP : TIPO_NEXT;
      COND_Z:      result = flags[FLAG_Z] ? TIPO_JUMP : TIPO_NEXT;
      COND_V:      result = flags[FLAG_V] ? TIPO_JUMP : TIPO_NEXT;
      COND_C:      result = flags[FLAG_C] ? TIPO_JUMP : TIPO_NEXT;
      COND_IR13:   result = ir13 ? TIPO_JUMP : TIPO_NEXT;
      COND_JUMP:   result = TIPO_JUMP;
      COND_DECODE: result = TIPO_DECODE;
      default:     result = TIPO_NEXT;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cbl_psr.sv
// rtl/cbl_psr.sv - processor status flag register {n,z,v,c} with load enable
module cbl_psr #(
  parameter int DATAWIDTH_FLAGS = 4
) (
  input  logic                       CBL_PSR_CLOCK_50,
  input  logic                       CBL_PSR_ResetInHigh_In,
  input  logic                       CBL_PSR_Load_In,
  input  logic [DATAWIDTH_FLAGS-1:0] CBL_PSR_Flags_InBus,
  output logic [DATAWIDTH_FLAGS-1:0] CBL_PSR_Flags_OutBus
);

  logic [DATAWIDTH_FLAGS-1:0] flagsReg;

  always_ff @(posedge CBL_PSR_CLOCK_50 or posedge CBL_PSR_ResetInHigh_In) begin
    if (CBL_PSR_ResetInHigh_In) begin
      flagsReg <= '0;
    end else if (CBL_PSR_Load_In) begin
      flagsReg <= CBL_PSR_Flags_InBus;
    end
  end

  assign CBL_PSR_Flags_OutBus = flagsReg;

endmodule

// File: rtl/cbl_sequencer.sv
// rtl/cbl_sequencer.sv - microsequencer branch logic with memory-wait stall and timeout microtrap
module cbl_sequencer
  import cbl_pkg::*;
#(
  parameter int                             DATAWIDTH_CSADDRESS = 11,
  parameter int                             DATAWIDTH_CBL       = 2,
  parameter int                             DATAWIDTH_COND      = 3,
  parameter int                             TIMEOUT_CYCLES      = 15,
  parameter logic [DATAWIDTH_CSADDRESS-1:0] TRAP_ADDRESS        = TRAP_ADDRESS_DEFAULT
) (
  input  logic                           CBL_SEQUENCER_CLOCK_50,
  input  logic                           CBL_SEQUENCER_ResetInHigh_In,
  input  logic [DATAWIDTH_CSADDRESS-1:0] CBL_SEQUENCER_CSAddress_InBus,
  input  logic [DATAWIDTH_COND-1:0]      CBL_SEQUENCER_Cond_InBus,
  input  logic [DATAWIDTH_CSADDRESS-1:0] CBL_SEQUENCER_JumpAddress_InBus,
  input  logic                           CBL_SEQUENCER_IR13_In,
  input  logic                           CBL_SEQUENCER_Rd_In,
  input  logic                           CBL_SEQUENCER_Wr_In,
  input  logic                           CBL_SEQUENCER_SetCC_In,
  input  logic [3:0]                     CBL_SEQUENCER_ALUFlags_InBus,
  input  logic                           CBL_SEQUENCER_MemAck_In,
  output logic [DATAWIDTH_CBL-1:0]       CBL_SEQUENCER_Tipo_OutBus,
  output logic [DATAWIDTH_CSADDRESS-1:0] CBL_SEQUENCER_JumpAddress_OutBus,
  output logic [DATAWIDTH_CSADDRESS-1:0] CBL_SEQUENCER_CSAI_OutBus,
  output logic                           CBL_SEQUENCER_MemReq_Out,
  output logic                           CBL_SEQUENCER_MemError_Out,
  output logic [3:0]                     CBL_SEQUENCER_Flags_OutBus
);

  localparam logic [3:0] TIMEOUT_LIMIT = 4'(TIMEOUT_CYCLES);
  localparam logic [DATAWIDTH_CSADDRESS-1:0] CSADDRESS_ONE =
    {{(DATAWIDTH_CSADDRESS-1){1'b0}}, 1'b1};

  state_t                         stateReg;
  state_t                         stateNext;
  logic [3:0]                     waitCount;
  logic [3:0]                     waitCountNext;
  logic [3:0]                     psrFlags;
  logic                           psrLoad;
  logic                           memRequest;
  tipo_t                          condTipo;
  tipo_t                          tipoSel;
  logic [DATAWIDTH_CSADDRESS-1:0] jumpSel;
  logic                           memReqSel;
  logic                           memErrorSel;

  assign memRequest = CBL_SEQUENCER_Rd_In | CBL_SEQUENCER_Wr_In;

  // Branch tests read the registered flags only, so a SetCC in the same cycle cannot feed back.
  assign condTipo = cond_decode(cond_t'(CBL_SEQUENCER_Cond_InBus), psrFlags,
                                CBL_SEQUENCER_IR13_In);

  always_ff @(posedge CBL_SEQUENCER_CLOCK_50 or posedge CBL_SEQUENCER_ResetInHigh_In) begin
    if (CBL_SEQUENCER_ResetInHigh_In) begin
      stateReg  <= ST_RUN;
      waitCount <= 4'd0;
    end else begin
      stateReg  <= stateNext;
      waitCount <= waitCountNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    waitCountNext = waitCount;
    tipoSel       = condTipo;
    jumpSel       = CBL_SEQUENCER_JumpAddress_InBus;
    memReqSel     = 1'b0;
    memErrorSel   = 1'b0;
    psrLoad       = 1'b0;

    case (stateReg)
      ST_RUN: begin
        if (!memRequest) begin
          psrLoad = CBL_SEQUENCER_SetCC_In;
        end else begin
          memReqSel = 1'b1;
          if (CBL_SEQUENCER_MemAck_In) begin
            psrLoad = CBL_SEQUENCER_SetCC_In;
          end else begin
            tipoSel       = TIPO_JUMP;
            jumpSel       = CBL_SEQUENCER_CSAddress_InBus;
            stateNext     = ST_WAIT;
            waitCountNext = 4'd1;
          end
        end
      end

      ST_WAIT: begin
        memReqSel = 1'b1;
        if (CBL_SEQUENCER_MemAck_In) begin
          psrLoad       = CBL_SEQUENCER_SetCC_In;
          stateNext     = ST_RUN;
          waitCountNext = 4'd0;
        end else begin
          // Holding re-issues the current microword by jumping to its own address.
          tipoSel = TIPO_JUMP;
          jumpSel = CBL_SEQUENCER_CSAddress_InBus;
          if (waitCount < TIMEOUT_LIMIT) begin
            waitCountNext = waitCount + 4'd1;
          end else begin
            stateNext = ST_TRAP;
          end
        end
      end

      ST_TRAP: begin
        tipoSel       = TIPO_JUMP;
        jumpSel       = TRAP_ADDRESS;
        memErrorSel   = 1'b1;
        stateNext     = ST_RUN;
        waitCountNext = 4'd0;
      end

      default: begin
        stateNext     = ST_RUN;
        waitCountNext = 4'd0;
      end
    endcase

    if (CBL_SEQUENCER_ResetInHigh_In) begin
      tipoSel     = TIPO_NEXT;
      jumpSel     = CBL_SEQUENCER_JumpAddress_InBus;
      memReqSel   = 1'b0;
      memErrorSel = 1'b0;
      psrLoad     = 1'b0;
    end
  end

  cbl_psr #(
    .DATAWIDTH_FLAGS(4)
  ) psrInst (
    .CBL_PSR_CLOCK_50      (CBL_SEQUENCER_CLOCK_50),
    .CBL_PSR_ResetInHigh_In(CBL_SEQUENCER_ResetInHigh_In),
    .CBL_PSR_Load_In       (psrLoad),
    .CBL_PSR_Flags_InBus   (CBL_SEQUENCER_ALUFlags_InBus),
    .CBL_PSR_Flags_OutBus  (psrFlags)
  );

  assign CBL_SEQUENCER_Tipo_OutBus        = DATAWIDTH_CBL'(tipoSel);
  assign CBL_SEQUENCER_JumpAddress_OutBus = jumpSel;
  assign CBL_SEQUENCER_CSAI_OutBus        = CBL_SEQUENCER_CSAddress_InBus + CSADDRESS_ONE;
  assign CBL_SEQUENCER_MemReq_Out         = memReqSel;
  assign CBL_SEQUENCER_MemError_Out       = memErrorSel;
  assign CBL_SEQUENCER_Flags_OutBus       = psrFlags;

endmodule

// File: tb/tb_cbl_sequencer.sv
// tb/tb_cbl_sequencer.sv - self-checking bench for cbl_sequencer
module tb_cbl_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] csAddr = '0;
  logic [2:0]  cond = '0;
  logic [10:0] jumpIn = '0;
  logic        ir13 = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        setCC = 1'b0;
  logic [3:0]  aluFlags = '0;
  logic        memAck = 1'b0;
  logic [1:0]  tipo;
  logic [10:0] jumpOut;
  logic [10:0] csai;
  logic        memReq;
  logic        memError;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  localparam int TIMEOUT = 15;

  cbl_sequencer dut (
    .CBL_SEQUENCER_CLOCK_50          (clk),
    .CBL_SEQUENCER_ResetInHigh_In    (rst),
    .CBL_SEQUENCER_CSAddress_InBus   (csAddr),
    .CBL_SEQUENCER_Cond_InBus        (cond),
    .CBL_SEQUENCER_JumpAddress_InBus (jumpIn),
    .CBL_SEQUENCER_IR13_In           (ir13),
    .CBL_SEQUENCER_Rd_In             (rd),
    .CBL_SEQUENCER_Wr_In             (wr),
    .CBL_SEQUENCER_SetCC_In          (setCC),
    .CBL_SEQUENCER_ALUFlags_InBus    (aluFlags),
    .CBL_SEQUENCER_MemAck_In         (memAck),
    .CBL_SEQUENCER_Tipo_OutBus       (tipo),
    .CBL_SEQUENCER_JumpAddress_OutBus(jumpOut),
    .CBL_SEQUENCER_CSAI_OutBus       (csai),
    .CBL_SEQUENCER_MemReq_Out        (memReq),
    .CBL_SEQUENCER_MemError_Out      (memError),
    .CBL_SEQUENCER_Flags_OutBus      (flags)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cond = 3'b000; rd = 1'b0; wr = 1'b0; setCC = 1'b0; memAck = 1'b0;
    aluFlags = 4'h0; ir13 = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    idle_inputs();
    setCC = 1'b1; aluFlags = f;
    step();
    setCC = 1'b0;
  endtask

  // Branch rule: cond 1..4 tests n,z,v,c which sit at bit 4-cond of {n,z,v,c}.
  function automatic logic [1:0] exp_cond_tipo(input logic [2:0] c, input logic [3:0] f,
                                               input logic ir);
    int ci;
    ci = int'(c);
    if (ci == 0) return 2'b00;
    if (ci <= 4) return f[4 - ci] ? 2'b01 : 2'b00;
    if (ci == 5) return ir ? 2'b01 : 2'b00;
    if (ci == 6) return 2'b01;
    return 2'b10;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rd = 1'b1; wr = 1'b1; memAck = 1'b1; setCC = 1'b1; aluFlags = 4'hF;
    cond = 3'b110; jumpIn = 11'h3A5; csAddr = 11'h100;
    #3;
    checks++; if (memReq !== 1'b0) begin $display("FAIL reset_memreq: got %b want 0", memReq); errors++; end
    checks++; if (memError !== 1'b0) begin $display("FAIL reset_memerror: got %b want 0", memError); errors++; end
    checks++; if (tipo !== 2'b00) begin $display("FAIL reset_tipo: got %b want 00", tipo); errors++; end
    checks++; if (jumpOut !== 11'h3A5) begin $display("FAIL reset_jump: got %h want 3a5", jumpOut); errors++; end
    step();
    #3;
    checks++; if (flags !== 4'h0) begin $display("FAIL reset_flags: got %b want 0000", flags); errors++; end
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    cond = 3'b111;
    #3;
    checks++; if (tipo !== 2'b10 || memReq !== 1'b0) begin
      $display("FAIL reset_release_run: got tipo=%b memreq=%b want tipo=10 memreq=0", tipo, memReq); errors++; end
    step();
  endtask

  task automatic test_cond_decode();
    load_flags(4'b0100);
    cond = 3'b010; jumpIn = 11'h123;
    #3;
    checks++; if (tipo !== 2'b01 || jumpOut !== 11'h123) begin
      $display("FAIL cond_z_taken: got tipo=%b jump=%h want tipo=01 jump=123", tipo, jumpOut); errors++; end
    step();
    load_flags(4'b0000);
    cond = 3'b010; jumpIn = 11'h123;
    #3;
    checks++; if (tipo !== 2'b00) begin $display("FAIL cond_z_not_taken: got tipo=%b want 00", tipo); errors++; end
    step();
    for (int i = 0; i < 24; i++) begin
      logic [3:0] f;
      f = 4'($urandom_range(0, 15));
      load_flags(f);
      cond = 3'($urandom_range(0, 7)); ir13 = 1'($urandom_range(0, 1));
      jumpIn = 11'($urandom_range(0, 2047));
      #3;
      checks++; if (tipo !== exp_cond_tipo(cond, f, ir13)) begin
        $display("FAIL cond_rand: cond=%b flags=%b ir13=%b got tipo=%b want %b", cond, f, ir13, tipo,
                 exp_cond_tipo(cond, f, ir13)); errors++; end
      if (exp_cond_tipo(cond, f, ir13) == 2'b01) begin
        checks++; if (jumpOut !== jumpIn) begin
          $display("FAIL cond_rand_jump: got %h want %h", jumpOut, jumpIn); errors++; end
      end
      step();
    end
  endtask

  task automatic test_csai();
    idle_inputs();
    csAddr = 11'h7FF; cond = 3'b111;
    #3;
    checks++; if (csai !== 11'h000) begin $display("FAIL csai_wrap: got %h want 000", csai); errors++; end
    checks++; if (tipo !== 2'b10) begin $display("FAIL cond_decode_111: got %b want 10", tipo); errors++; end
    step();
    for (int i = 0; i < 8; i++) begin
      int a;
      a = int'($urandom_range(0, 2047));
      csAddr = 11'(a);
      #3;
      checks++; if (csai !== 11'((a + 1) % 2048)) begin
        $display("FAIL csai_rand: addr=%h got %h want %h", csAddr, csai, 11'((a + 1) % 2048)); errors++; end
      step();
    end
  endtask

  task automatic test_rd_stall();
    idle_inputs();
    csAddr = 11'h040; jumpIn = 11'h2AA; cond = 3'b111; rd = 1'b1;
    for (int c = 0; c < 3; c++) begin
      memAck = (c == 2);
      #3;
      checks++; if (memReq !== 1'b1) begin $display("FAIL rd_memreq c%0d: got %b want 1", c, memReq); errors++; end
      if (c < 2) begin
        checks++; if (tipo !== 2'b01 || jumpOut !== 11'h040) begin
          $display("FAIL rd_hold c%0d: got tipo=%b jump=%h want 01/040", c, tipo, jumpOut); errors++; end
      end else begin
        checks++; if (tipo !== 2'b10) begin $display("FAIL rd_complete: got tipo=%b want 10", tipo); errors++; end
      end
      step();
    end
    idle_inputs();
    #3;
    checks++; if (memReq !== 1'b0 || tipo !== 2'b00) begin
      $display("FAIL rd_after: got memreq=%b tipo=%b want 0/00", memReq, tipo); errors++; end
    step();
  endtask

  task automatic test_timeout();
    load_flags(4'b0110);
    csAddr = 11'h155; jumpIn = 11'h0AA; cond = 3'b110; wr = 1'b1;
    for (int c = 0; c < TIMEOUT + 1; c++) begin
      #3;
      checks++; if (memReq !== 1'b1 || memError !== 1'b0 || tipo !== 2'b01 || jumpOut !== 11'h155) begin
        $display("FAIL timeout_hold c%0d: got req=%b err=%b tipo=%b jump=%h want 1/0/01/155",
                 c, memReq, memError, tipo, jumpOut); errors++; end
      step();
    end
    memAck = 1'b1; setCC = 1'b1; aluFlags = 4'b1001;
    #3;
    checks++; if (memError !== 1'b1 || memReq !== 1'b0 || tipo !== 2'b01 || jumpOut !== 11'h7F0) begin
      $display("FAIL timeout_trap: got err=%b req=%b tipo=%b jump=%h want 1/0/01/7f0",
               memError, memReq, tipo, jumpOut); errors++; end
    step();
    idle_inputs();
    #3;
    checks++; if (memError !== 1'b0 || memReq !== 1'b0 || tipo !== 2'b00) begin
      $display("FAIL timeout_after: got err=%b req=%b tipo=%b want 0/0/00", memError, memReq, tipo); errors++; end
    checks++; if (flags !== 4'b0110) begin $display("FAIL trap_no_flag_load: got %b want 0110", flags); errors++; end
    step();
  endtask

  task automatic test_setcc_stall();
    load_flags(4'b0000);
    rd = 1'b1; setCC = 1'b1; aluFlags = 4'b1011; cond = 3'b001; jumpIn = 11'h321; csAddr = 11'h050;
    for (int c = 0; c < 3; c++) begin
      memAck = (c == 2);
      #3;
      checks++; if (flags !== 4'b0000) begin $display("FAIL setcc_stall_flags c%0d: got %b want 0000", c, flags); errors++; end
      if (c == 2) begin
        checks++; if (tipo !== 2'b00) begin $display("FAIL setcc_old_flags: got tipo=%b want 00", tipo); errors++; end
      end
      step();
    end
    idle_inputs();
    cond = 3'b001; jumpIn = 11'h321;
    #3;
    checks++; if (flags !== 4'b1011) begin $display("FAIL setcc_loaded: got %b want 1011", flags); errors++; end
    checks++; if (tipo !== 2'b01 || jumpOut !== 11'h321) begin
      $display("FAIL setcc_new_flags: got tipo=%b jump=%h want 01/321", tipo, jumpOut); errors++; end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int holds;
    bit sawTrap;
    load_flags(4'b1111);
    rd = 1'b1; csAddr = 11'h222;
    step(); step(); step();
    #1 rst = 1'b1;
    #1;
    checks++; if (memReq !== 1'b0 || flags !== 4'b0000 || memError !== 1'b0) begin
      $display("FAIL reset_mid_wait: got req=%b flags=%b err=%b want 0/0000/0", memReq, flags, memError); errors++; end
    step();
    #3;
    checks++; if (memError !== 1'b0) begin $display("FAIL reset_no_error: got %b want 0", memError); errors++; end
    step();
    rst = 1'b0;
    idle_inputs();
    cond = 3'b111;
    #3;
    checks++; if (memReq !== 1'b0 || tipo !== 2'b10) begin
      $display("FAIL reset_back_run: got req=%b tipo=%b want 0/10", memReq, tipo); errors++; end
    step();
    wr = 1'b1; cond = 3'b000;
    holds = 0; sawTrap = 0;
    for (int c = 0; c < 40 && !sawTrap; c++) begin
      #3;
      if (memError) sawTrap = 1;
      else holds++;
      step();
    end
    checks++; if (!sawTrap || holds != TIMEOUT + 1) begin
      $display("FAIL reset_counter_cleared: trap=%0d holds=%0d want trap=1 holds=%0d", sawTrap, holds, TIMEOUT + 1);
      errors++; end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    logic [3:0] mFlags;
    int         mStall;
    bit         mTrap;
    int         ackDen;
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    mFlags = 4'h0; mStall = 0; mTrap = 0; ackDen = 1;
    for (int c = 0; c < 600; c++) begin
      logic [1:0]  eTipo;
      logic [10:0] eJump;
      bit          chkJump;
      bit          eReq;
      bit          eErr;
      bit          pending;
      logic [3:0]  nFlags;
      if (c % 50 == 0) ackDen = (c % 150 == 100) ? 24 : int'($urandom_range(1, 4));
      rd = ($urandom_range(0, 3) == 0); wr = ($urandom_range(0, 5) == 0);
      memAck = ($urandom_range(0, ackDen) == 0); setCC = 1'($urandom_range(0, 1));
      aluFlags = 4'($urandom_range(0, 15)); cond = 3'($urandom_range(0, 7));
      ir13 = 1'($urandom_range(0, 1)); jumpIn = 11'($urandom_range(0, 2047));
      csAddr = 11'($urandom_range(0, 2047));
      nFlags = mFlags; eErr = 0; chkJump = 0; eJump = jumpIn;
      if (mTrap) begin
        eTipo = 2'b01; eJump = 11'h7F0; chkJump = 1; eReq = 0; eErr = 1;
        mTrap = 0; mStall = 0;
      end else begin
        pending = (mStall > 0) || rd || wr;
        if (pending && !memAck) begin
          eTipo = 2'b01; eJump = csAddr; chkJump = 1; eReq = 1;
          mStall++;
          if (mStall == TIMEOUT + 1) begin mTrap = 1; mStall = 0; end
        end else begin
          eTipo = exp_cond_tipo(cond, mFlags, ir13); chkJump = (eTipo == 2'b01); eReq = pending;
          if (setCC) nFlags = aluFlags;
          mStall = 0;
        end
      end
      #3;
      checks++; if (tipo !== eTipo) begin $display("FAIL rand_tipo c%0d: got %b want %b", c, tipo, eTipo); errors++; end
      checks++; if (memReq !== eReq || memError !== eErr) begin
        $display("FAIL rand_mem c%0d: got req=%b err=%b want %b/%b", c, memReq, memError, eReq, eErr); errors++; end
      checks++; if (flags !== mFlags) begin $display("FAIL rand_flags c%0d: got %b want %b", c, flags, mFlags); errors++; end
      checks++; if (csai !== csAddr + 11'd1) begin $display("FAIL rand_csai c%0d: got %h want %h", c, csai, csAddr + 11'd1); errors++; end
      if (chkJump) begin
        checks++; if (jumpOut !== eJump) begin $display("FAIL rand_jump c%0d: got %h want %h", c, jumpOut, eJump); errors++; end
      end
      mFlags = nFlags;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #1;
    test_reset();
    test_cond_decode();
    test_csai();
    test_rd_stall();
    test_timeout();
    test_setcc_stall();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbl_sequencer.md
CBL_SEQUENCER -- requirements
Module: cbl_sequencer

Interface
REQ-001 Parameters SHALL be: DATAWIDTH_CSADDRESS=11 (control-store address width); DATAWIDTH_CBL=2 (Tipo width); DATAWIDTH_COND=3 (microword COND field width); TIMEOUT_CYCLES=15 (maximum WAIT cycles); TRAP_ADDRESS=11'h7F0 (microtrap entry).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports named in the codebase style:
- CBL_SEQUENCER_CLOCK_50, input, 1: clock.
- CBL_SEQUENCER_ResetInHigh_In, input, 1: asynchronous, active-high reset.
- CBL_SEQUENCER_CSAddress_InBus, input, 11: current control-store address.
- CBL_SEQUENCER_Cond_InBus, input, 3: microword COND field.
- CBL_SEQUENCER_JumpAddress_InBus, input, 11: microword JUMP ADDR field.
- CBL_SEQUENCER_IR13_In, input, 1: instruction register bit 13.
- CBL_SEQUENCER_Rd_In, input, 1: microword memory read request.
- CBL_SEQUENCER_Wr_In, input, 1: microword memory write request.
- CBL_SEQUENCER_SetCC_In, input, 1: load the condition codes.
- CBL_SEQUENCER_ALUFlags_InBus, input, 4: ALU flags {n,z,v,c}.
- CBL_SEQUENCER_MemAck_In, input, 1: memory done.
- CBL_SEQUENCER_Tipo_OutBus, output, 2: address-source select (00 next, 01 jump, 10 decode).
- CBL_SEQUENCER_JumpAddress_OutBus, output, 11: jump target.
- CBL_SEQUENCER_CSAI_OutBus, output, 11: incremented address.
- CBL_SEQUENCER_MemReq_Out, output, 1: memory request.
- CBL_SEQUENCER_MemError_Out, output, 1: timeout pulse.
- CBL_SEQUENCER_Flags_OutBus, output, 4: registered PSR flags {n,z,v,c}.

Function
REQ-003 CSAI SHALL equal CSAddress_InBus+1 modulo 2^11, so 11'h7FF wraps to 11'h000.
REQ-004 The FSM SHALL have three states, RUN, WAIT and TRAP, and all outputs SHALL be combinational from the state, the counter, the flags and the inputs (zero added latency).
REQ-005 COND decoding SHALL apply in RUN with Rd=Wr=0, and in WAIT on the MemAck=1 cycle:
- 000: Tipo=00.
- 001/010/011/100: test n/z/v/c respectively; Tipo=01 if the flag is 1, else 00.
- 101: test IR13; Tipo=01 if IR13 is 1, else 00.
- 110: Tipo=01.
- 111: Tipo=10.
REQ-006 When Tipo=01 comes from COND decoding, JumpAddress_OutBus SHALL equal JumpAddress_InBus.
REQ-007 Condition tests SHALL use the registered flags, never the same-cycle ALUFlags_InBus.
REQ-008 In RUN with Rd or Wr set, MemReq SHALL be 1; if MemAck=1 in the same cycle the microinstruction completes per REQ-005 and the FSM stays in RUN; otherwise the FSM goes to WAIT, the wait counter loads 1, and Tipo=01 with JumpAddress_OutBus=CSAddress_InBus (hold).
REQ-009 In WAIT, MemReq SHALL be 1.
- MemAck=1: complete per REQ-005, go to RUN, clear the counter.
- MemAck=0 and counter<TIMEOUT_CYCLES: hold per REQ-008 and increment the counter.
- MemAck=0 and counter=TIMEOUT_CYCLES: hold and go to TRAP.
REQ-010 TRAP SHALL last exactly one cycle with Tipo=01, JumpAddress_OutBus=TRAP_ADDRESS, MemError=1 and MemReq=0, then go to RUN with the counter cleared.
REQ-011 Flags SHALL load ALUFlags_InBus only on the completing cycle of a microinstruction with SetCC=1; they SHALL NOT load during hold cycles or in TRAP.
REQ-012 Rd and Wr both set SHALL be treated as a single request.
REQ-013 MemAck outside RUN/WAIT with a request SHALL be ignored.
REQ-014 The wait counter SHALL be 4 bits and SHALL never exceed TIMEOUT_CYCLES.

Reset
REQ-015 Reset assertion SHALL asynchronously force state=RUN, counter=0 and flags=0000.
REQ-016 While reset is asserted, MemReq=0, MemError=0, Tipo=00, JumpAddress_OutBus=JumpAddress_InBus and Flags_OutBus=0000.
REQ-017 Reset in WAIT or TRAP SHALL abort the access with no MemError pulse.

Structure
REQ-018 A shared package cbl_pkg SHALL hold the COND encodings, the Tipo encodings (NEXT/JUMP/DECODE), the FSM state encodings and the default TRAP_ADDRESS.
REQ-019 Sub-module cbl_psr SHALL implement the 4-bit flag register with async reset and load enable; everything else is flat.

Verification
REQ-020 A bench SHALL cover these directed scenarios:
- Flags=0100, Cond=010, Jump=11'h123 -> Tipo=01, JumpAddress_OutBus=11'h123; with flags=0000 -> Tipo=00.
- CSAddress=11'h7FF -> CSAI=11'h000; Cond=111 -> Tipo=10.
- Rd=1, MemAck at the 3rd cycle, CSAddress=11'h040 -> 2 hold cycles with Tipo=01 and JumpAddress_OutBus=11'h040, MemReq=1 for 3 cycles, then COND applies.
- Wr=1, no MemAck -> after 15 WAIT cycles, one TRAP cycle with JumpAddress_OutBus=11'h7F0 and MemError=1, then RUN.
- SetCC=1 with ALUFlags=1011 during a stall -> Flags unchanged until the ack cycle, then 1011; Cond=001 in the same cycle uses the old flags.
- Reset asserted mid-WAIT -> MemReq=0 and Flags=0000 immediately; after release, state is RUN and the counter is 0.
